// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store stage: req/ack bus master with one-cycle register write-back
// Bus timeout and load/store conflicts raise a sticky error flag.
module load_store_unit #(
    parameter int W  = 8,
    parameter int D  = 4,
    parameter int TO = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         LoadReq,
    input  logic         StoreReq,
    input  logic [W-1:0] Addr,
    input  logic [W-1:0] StoreData,
    input  logic [D-1:0] DestReg,
    output logic         Stall,
    output logic         WbEn,
    output logic [D-1:0] WbAddr,
    output logic [W-1:0] WbData,
    output logic         MemReq,
    output logic         MemWe,
    output logic [W-1:0] MemAddr,
    output logic [W-1:0] MemWData,
    input  logic [W-1:0] MemRData,
    input  logic         MemAck,
    output logic         Err
);

    localparam int CW = $clog2(TO + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           mem_we_q, mem_we_d;
    logic [W-1:0]   mem_addr_q, mem_addr_d;
    logic [W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [D-1:0]   dest_q, dest_d;
    logic [D-1:0]   wb_addr_q, wb_addr_d;
    logic [W-1:0]   wb_data_q, wb_data_d;
    logic           err_q, err_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cnt_inc;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            dest_q      <= '0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            dest_q      <= dest_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        dest_d      = dest_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        cnt_inc     = cnt_q + CW'(1);
        case (state_q)
            IDLE: begin
                if (LoadReq || StoreReq) begin
                    state_d     = BUS;
                    // a simultaneous load wins; the store is dropped and flagged
                    mem_we_d    = ~LoadReq;
                    mem_addr_d  = Addr;
                    mem_wdata_d = StoreData;
                    dest_d      = DestReg;
                    cnt_d       = '0;
                    if (LoadReq && StoreReq) err_d = 1'b1;
                end
            end
            BUS: begin
                if (MemAck) begin
                    if (mem_we_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = WB;
                        wb_data_d = MemRData;
                        wb_addr_d = dest_q;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(TO)) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        MemReq   = (state_q == BUS);
        WbEn     = (state_q == WB);
        Stall    = ((state_q == IDLE) && (LoadReq || StoreReq)) || (state_q != IDLE);
        MemWe    = mem_we_q;
        MemAddr  = mem_addr_q;
        MemWData = mem_wdata_q;
        WbAddr   = wb_addr_q;
        WbData   = wb_data_q;
        Err      = err_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_req, store_req;
    logic [7:0] addr, store_data;
    logic [3:0] dest_reg;
    logic       stall, wb_en;
    logic [3:0] wb_addr;
    logic [7:0] wb_data;
    logic       mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_ack;
    logic       err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.W(8), .D(4), .TO(16)) dut (
        .Clk(clk), .Reset(reset), .LoadReq(load_req), .StoreReq(store_req),
        .Addr(addr), .StoreData(store_data), .DestReg(dest_reg),
        .Stall(stall), .WbEn(wb_en), .WbAddr(wb_addr), .WbData(wb_data),
        .MemReq(mem_req), .MemWe(mem_we), .MemAddr(mem_addr), .MemWData(mem_wdata),
        .MemRData(mem_rdata), .MemAck(mem_ack), .Err(err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        load_req = 1'b0; store_req = 1'b0; mem_ack = 1'b0;
        step;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        load_req = 1'b0; store_req = 1'b0; mem_ack = 1'b0;
        addr = 8'h00; store_data = 8'h00; dest_reg = 4'h0; mem_rdata = 8'h00;
        step; step;
        @(negedge clk);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_memreq got=%b want=0", mem_req); end
        total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL reset_wben got=%b want=0", wb_en); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if ({wb_addr, wb_data, mem_addr, mem_wdata} !== 28'h0) begin
            bad++; $display("FAIL reset_regs got=%h want=0", {wb_addr, wb_data, mem_addr, mem_wdata});
        end
        step;
        reset = 1'b0;
    endtask

    task automatic test_load_immediate;
        int mr = 0, wb = 0, st = 0, wb_cyc = -1;
        load_req = 1'b1; addr = 8'h20; dest_reg = 4'd3; mem_ack = 1'b1; mem_rdata = 8'hA5;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (stall) st++;
            if (mem_req) begin
                mr++;
                total++;
                if (mem_we !== 1'b0 || mem_addr !== 8'h20) begin
                    bad++; $display("FAIL load_bus we=%b addr=%h want we=0 addr=20", mem_we, mem_addr);
                end
            end
            if (wb_en) begin
                wb++; wb_cyc = c;
                total++;
                if (wb_addr !== 4'd3 || wb_data !== 8'hA5) begin
                    bad++; $display("FAIL load_wb addr=%0d data=%h want addr=3 data=a5", wb_addr, wb_data);
                end
            end
            step;
            load_req = 1'b0;
        end
        mem_ack = 1'b0;
        total++; if (mr != 1) begin bad++; $display("FAIL load_memreq_cycles got=%0d want=1", mr); end
        total++; if (wb != 1) begin bad++; $display("FAIL load_wben_cycles got=%0d want=1", wb); end
        total++; if (wb_cyc != 2) begin bad++; $display("FAIL load_wben_cycle got=%0d want=2", wb_cyc); end
        total++; if (st != 3) begin bad++; $display("FAIL load_stall_cycles got=%0d want=3", st); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL load_err got=%b want=0", err); end
    endtask

    task automatic test_store_delayed;
        int mr = 0, wb = 0, st = 0, last_st = -1;
        store_req = 1'b1; addr = 8'h10; store_data = 8'h5C; mem_ack = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (stall) begin st++; last_st = c; end
            if (mem_req) begin
                mr++;
                total++;
                if (mem_we !== 1'b1 || mem_wdata !== 8'h5C || mem_addr !== 8'h10) begin
                    bad++; $display("FAIL store_bus we=%b addr=%h wdata=%h want we=1 addr=10 wdata=5c",
                                    mem_we, mem_addr, mem_wdata);
                end
            end
            if (wb_en) wb++;
            step;
            store_req = 1'b0;
            store_data = 8'hFF;
            mem_ack = (c + 1 == 5);
        end
        mem_ack = 1'b0;
        total++; if (mr != 5) begin bad++; $display("FAIL store_memreq_cycles got=%0d want=5", mr); end
        total++; if (wb != 0) begin bad++; $display("FAIL store_wben_cycles got=%0d want=0", wb); end
        total++; if (st != 6) begin bad++; $display("FAIL store_stall_cycles got=%0d want=6", st); end
        total++; if (last_st != 5) begin bad++; $display("FAIL store_stall_last got=%0d want=5", last_st); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL store_err got=%b want=0", err); end
    endtask

    task automatic test_timeout;
        int mr = 0, wb = 0, st = 0, wb2 = 0;
        logic [3:0] wa = 4'h0;
        logic [7:0] wd = 8'h00;
        load_req = 1'b1; addr = 8'h30; dest_reg = 4'd7; mem_ack = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (stall) st++;
            if (mem_req) mr++;
            if (wb_en) wb++;
            step;
            load_req = 1'b0;
        end
        total++; if (mr != 16) begin bad++; $display("FAIL timeout_memreq_cycles got=%0d want=16", mr); end
        total++; if (st != 17) begin bad++; $display("FAIL timeout_stall_cycles got=%0d want=17", st); end
        total++; if (wb != 0) begin bad++; $display("FAIL timeout_wben got=%0d want=0", wb); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b want=1", err); end
        load_req = 1'b1; addr = 8'h31; dest_reg = 4'd6; mem_ack = 1'b1; mem_rdata = 8'h77;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (wb_en) begin wb2++; wa = wb_addr; wd = wb_data; end
            step;
            load_req = 1'b0;
        end
        mem_ack = 1'b0;
        total++; if (wb2 != 1 || wa !== 4'd6 || wd !== 8'h77) begin
            bad++; $display("FAIL timeout_followup n=%0d addr=%0d data=%h want n=1 addr=6 data=77", wb2, wa, wd);
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL timeout_err_sticky got=%b want=1", err); end
    endtask

    task automatic test_conflict;
        int mr = 0, stores = 0, wb = 0;
        logic [3:0] wa = 4'h0;
        logic [7:0] wd = 8'h00;
        do_reset;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL conflict_err_cleared got=%b want=0", err); end
        load_req = 1'b1; store_req = 1'b1; addr = 8'h40; store_data = 8'h99; dest_reg = 4'd5;
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (mem_req) mr++;
            if (mem_req && mem_we) stores++;
            if (wb_en) begin wb++; wa = wb_addr; wd = wb_data; end
            step;
            load_req = 1'b0; store_req = 1'b0;
        end
        mem_ack = 1'b0;
        total++; if (mr != 1 || stores != 0) begin
            bad++; $display("FAIL conflict_bus reqs=%0d stores=%0d want reqs=1 stores=0", mr, stores);
        end
        total++; if (wb != 1 || wa !== 4'd5 || wd !== 8'h3C) begin
            bad++; $display("FAIL conflict_wb n=%0d addr=%0d data=%h want n=1 addr=5 data=3c", wb, wa, wd);
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL conflict_err got=%b want=1", err); end
    endtask

    task automatic test_reset_mid_access;
        int wb = 0;
        logic req2 = 1'b0, req3 = 1'b1;
        do_reset;
        load_req = 1'b1; addr = 8'h50; dest_reg = 4'd4; mem_ack = 1'b0; mem_rdata = 8'hEE;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) req2 = mem_req;
            if (c == 3) req3 = mem_req;
            if (wb_en) wb++;
            step;
            load_req = 1'b0;
            if (c + 1 == 2) reset = 1'b1;
            if (c + 1 == 3) begin reset = 1'b0; mem_ack = 1'b1; end
        end
        @(negedge clk);
        total++; if (req2 !== 1'b1) begin bad++; $display("FAIL midreset_bus2 got=%b want=1", req2); end
        total++; if (req3 !== 1'b0) begin bad++; $display("FAIL midreset_drop got=%b want=0", req3); end
        total++; if (wb != 0) begin bad++; $display("FAIL midreset_wben got=%0d want=0", wb); end
        total++; if (err !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL midreset_idle err=%b stall=%b want err=0 stall=0", err, stall);
        end
        step;
        mem_ack = 1'b0;
    endtask

    task automatic test_back_to_back;
        int st = 0, wb = 0;
        int cyc[2] = '{-1, -1};
        logic [3:0] wa[2] = '{4'h0, 4'h0};
        logic [7:0] wd[2] = '{8'h00, 8'h00};
        logic st3 = 1'b0;
        do_reset;
        load_req = 1'b1; addr = 8'h01; dest_reg = 4'd1; mem_ack = 1'b1; mem_rdata = 8'h11;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (stall) st++;
            if (c == 3) st3 = stall;
            if (wb_en) begin
                if (wb < 2) begin cyc[wb] = c; wa[wb] = wb_addr; wd[wb] = wb_data; end
                wb++;
            end
            step;
            if (c + 1 == 1) begin addr = 8'h02; dest_reg = 4'd2; end
            if (c + 1 == 3) mem_rdata = 8'h22;
            if (c + 1 == 4) load_req = 1'b0;
        end
        mem_ack = 1'b0;
        total++; if (wb != 2) begin bad++; $display("FAIL b2b_wben_count got=%0d want=2", wb); end
        total++; if (cyc[0] != 2 || wa[0] !== 4'd1 || wd[0] !== 8'h11) begin
            bad++; $display("FAIL b2b_first cyc=%0d addr=%0d data=%h want cyc=2 addr=1 data=11", cyc[0], wa[0], wd[0]);
        end
        total++; if (cyc[1] != 5 || wa[1] !== 4'd2 || wd[1] !== 8'h22) begin
            bad++; $display("FAIL b2b_second cyc=%0d addr=%0d data=%h want cyc=5 addr=2 data=22", cyc[1], wa[1], wd[1]);
        end
        total++; if (st3 !== 1'b1 || st != 6) begin
            bad++; $display("FAIL b2b_stall c3=%b cycles=%0d want c3=1 cycles=6", st3, st);
        end
    endtask

    initial begin
        test_reset;
        test_load_immediate;
        test_store_delayed;
        test_timeout;
        test_conflict;
        test_reset_mid_access;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage that sits directly upstream of the register file write port.
- Accepts one load or store per request from decode. Drives a req/ack memory bus, stalls the core while the access is outstanding, and returns load data as a one-cycle write-back (WbEn/WbAddr/WbData) into the register file.
- Provides a bus timeout with a sticky error flag.

Parameters:
- W, 8, data and address width in bits
- D, 4, register-address width (register file has 2**D entries)
- TO, 16, maximum number of cycles MemReq may stay high without MemAck before the access aborts (TO >= 1)

Ports:
- Clk  input  1  clock, all state updates on posedge
- Reset  input  1  synchronous, active-high
- LoadReq  input  1  request a load this cycle
- StoreReq  input  1  request a store this cycle
- Addr  input  W  memory address, sampled on accept
- StoreData  input  W  store data, sampled on accept
- DestReg  input  D  load destination register, sampled on accept
- Stall  output  1  core must hold; requests are ignored while this block is busy
- WbEn  output  1  register-file write enable, one-cycle pulse
- WbAddr  output  D  register-file write address
- WbData  output  W  register-file write data
- MemReq  output  1  bus request
- MemWe  output  1  1 = store, 0 = load; valid while MemReq
- MemAddr  output  W  bus address; valid while MemReq
- MemWData  output  W  bus write data; valid while MemReq and MemWe
- MemRData  input  W  bus read data; valid with MemAck
- MemAck  input  1  bus acknowledge; sampled only while MemReq=1
- Err  output  1  sticky timeout/conflict flag

Behaviour:
- States:
  - IDLE.
  - BUS: MemReq=1.
  - WB: WbEn=1.
- Reset:
  - Next state is IDLE. All registered outputs (MemReq, MemWe, MemAddr, MemWData, WbEn, WbAddr, WbData, Err) and the timeout counter go to 0.
  - Reset mid-access drops MemReq at that edge and produces no WbEn. A later MemAck is ignored.
- Request accept (IDLE only):
  - When LoadReq or StoreReq is 1 at a posedge in IDLE, latch Addr, StoreData, DestReg and the type, then enter BUS.
  - LoadReq and StoreReq both high: perform the load, drop the store, set Err.
- Stall (combinational):
  - Stall = (IDLE & (LoadReq | StoreReq)) | BUS | WB.
  - Requests arriving outside IDLE are ignored.
- BUS state:
  - MemReq=1; MemWe, MemAddr and MemWData stay stable until exit.
  - MemAck=1 at a posedge, load: capture MemRData into WbData, DestReg into WbAddr, go to WB.
  - MemAck=1 at a posedge, store: go to IDLE; WbEn stays 0.
  - MemAck=0: increment the counter. If MemReq has now been high for TO cycles, go to IDLE, set Err, and produce no write-back.
  - Counter width is clog2(TO+1). It clears on entry to BUS and does not wrap.
- WB state:
  - WbEn=1 for exactly one cycle, then IDLE.
  - The core resumes in the cycle after WB.
- MemAck outside BUS is ignored.
- Err behaviour:
  - Sticky; cleared only by Reset.
  - Does not block further requests.
- Latency, load with immediate ack:
  - Accept at edge 0.
  - MemReq high in cycle 1; ack sampled at edge 1.
  - WbEn high in cycle 2.
  - IDLE in cycle 3.
  - Total: 3 stall cycles.
- Latency, store with immediate ack: 2 stall cycles.
- Back-to-back: a new request can be accepted in the first IDLE cycle after completion.

Test Plan:
- Reset, then LoadReq=1, Addr=0x20, DestReg=3, MemAck tied high with MemRData=0xA5:
  - MemReq high exactly 1 cycle with MemWe=0, MemAddr=0x20.
  - WbEn pulses 1 cycle with WbAddr=3, WbData=0xA5.
  - Stall high for 3 cycles; Err=0.
- StoreReq=1, Addr=0x10, StoreData=0x5C, MemAck delayed 4 cycles:
  - MemReq/MemWe high for 5 cycles with MemWData=0x5C held stable.
  - No WbEn; Stall drops the cycle after the ack.
- Load with MemAck never asserted, TO=16:
  - MemReq high exactly 16 cycles, then returns to IDLE.
  - Err=1 and stays 1; no WbEn.
  - A subsequent acked load still completes normally.
- LoadReq=StoreReq=1 in the same cycle:
  - Load is performed (MemWe=0), no store appears on the bus, Err=1.
- Reset asserted in the 2nd BUS cycle of a load:
  - MemReq=0 at the next edge, no WbEn.
  - A late MemAck=1 is ignored; Err=0.
- Two loads back-to-back with immediate ack (DestReg 1 then 2, data 0x11 then 0x22):
  - Second request is ignored while Stall=1 and re-presented in the first IDLE cycle.
  - WbEn pulses at cycles 2 and 5 with the correct address/data pairs.
